cordic_ppl_arbiter: RTL and testbench

- Shares one pipelined CORDIC cosine unit between two requesters, e.g. two custom-instruction slots or a host port plus a DMA streamer.
- Arbitrates round-robin and issues at most one operand per cycle into the pipeline.
- Tracks the owner of every in-flight operand in a tag shift register that stays aligned with the pipeline.
- Routes each result back to its owner, and freezes the whole pipeline through its clock enable when the owner cannot accept the result.

---
 rtl/cordic_ppl_arbiter.sv | 122 ++++++++++++
 tb/tb_cordic_ppl_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ppl_arbiter.sv
// Round-robin arbiter sharing one pipelined CORDIC unit between two requesters.
// A tag shift register follows each operand through the pipeline so its result returns to the right owner.
module cordic_ppl_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              pipe_aclr,
    output logic              pipe_clk_en,
    output logic [DATA_W-1:0] pipe_dataa,
    input  logic [DATA_W-1:0] pipe_result,
    output logic              busy0,
    output logic              busy1
);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] tag;
    logic               rr_ptr;
    logic [CNT_W-1:0]   cnt0;
    logic [CNT_W-1:0]   cnt1;

    logic tail_vld;
    logic tail_tag;
    logic stall;
    logic grant0;
    logic grant1;
    logic grant_any;
    logic hs0;
    logic hs1;

    assign tail_vld  = vld[LATENCY-1];
    assign tail_tag  = tag[LATENCY-1];
    assign pipe_aclr = reset;
    assign rsp0_data = pipe_result;
    assign rsp1_data = pipe_result;

    always_comb begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        stall      = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (!reset) begin
            rsp0_valid = tail_vld & ~tail_tag;
            rsp1_valid = tail_vld & tail_tag;
            stall      = tail_vld & (tail_tag ? ~rsp1_ready : ~rsp0_ready);
            // rr_ptr only matters under contention; a lone requester always wins
            if (!stall) begin
                if (req0_valid && (!req1_valid || !rr_ptr)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_any   = grant0 | grant1;
        req0_ready  = grant0;
        req1_ready  = grant1;
        pipe_clk_en = ~stall;
        hs0         = rsp0_valid & rsp0_ready;
        hs1         = rsp1_valid & rsp1_ready;
        busy0       = ~reset & (cnt0 != '0);
        busy1       = ~reset & (cnt1 != '0);
        if (grant0) begin
            pipe_dataa = req0_data;
        end else if (grant1) begin
            pipe_dataa = req1_data;
        end else begin
            pipe_dataa = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld    <= '0;
            tag    <= '0;
            rr_ptr <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            if (!stall) begin
                vld[0] <= grant_any;
                tag[0] <= grant1;
                for (int i = 1; i < LATENCY; i++) begin
                    vld[i] <= vld[i-1];
                    tag[i] <= tag[i-1];
                end
                if (grant_any) begin
                    rr_ptr <= ~grant1;
                end
            end
            if (grant0 && !hs0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end else if (!grant0 && hs0) begin
                cnt0 <= cnt0 - CNT_W'(1);
            end
            if (grant1 && !hs1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end else if (!grant1 && hs1) begin
                cnt1 <= cnt1 - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cordic_ppl_arbiter.sv
// Bench for cordic_ppl_arbiter: behavioural pipeline model, per-requester scoreboards, directed scenarios.
module tb_cordic_ppl_arbiter;

    localparam int DATA_W  = 32;
    localparam int LATENCY = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              pipe_aclr, pipe_clk_en;
    logic [DATA_W-1:0] pipe_dataa, pipe_result;
    logic              busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int grant_log[$];
    int n_rsp0, n_rsp1, first_rsp_cyc, last_rsp_cyc;
    logic [DATA_W-1:0] d0 = 32'h0000_1000;
    logic [DATA_W-1:0] d1 = 32'h0000_2000;

    logic [DATA_W-1:0] pstage[LATENCY];

    always #5 clock = ~clock;

    cordic_ppl_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .pipe_aclr(pipe_aclr), .pipe_clk_en(pipe_clk_en),
        .pipe_dataa(pipe_dataa), .pipe_result(pipe_result),
        .busy0(busy0), .busy1(busy1)
    );

    function automatic logic [DATA_W-1:0] cordic_f(input logic [DATA_W-1:0] x);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Stand-in for the CORDIC core: clock-enabled shift of f(operand)
    always @(posedge clock) begin
        if (pipe_aclr) begin
            for (int i = 0; i < LATENCY; i++) pstage[i] <= '0;
        end else if (pipe_clk_en) begin
            pstage[0] <= cordic_f(pipe_dataa);
            for (int i = 1; i < LATENCY; i++) pstage[i] <= pstage[i-1];
        end
    end
    assign pipe_result = pstage[LATENCY-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                q0.push_back(cordic_f(req0_data));
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(cordic_f(req1_data));
                grant_log.push_back(1);
            end
            check_eq("one_grant", 32'(req0_ready & req1_ready), 0);
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) check_eq("rsp0_unexpected", 1, 0);
                else check_eq("rsp0_data", rsp0_data, q0.pop_front());
                n_rsp0++;
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
                last_rsp_cyc = cyc;
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) check_eq("rsp1_unexpected", 1, 0);
                else check_eq("rsp1_data", rsp1_data, q1.pop_front());
                n_rsp1++;
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
                last_rsp_cyc = cyc;
            end
        end
    end

    task automatic drive_until(input bit v0, input bit v1, input int n);
        int got = 0;
        int budget = 0;
        bit a0, a1;
        req0_valid = v0;
        req1_valid = v1;
        while (got < n && budget < 200) begin
            @(negedge clock);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clock); #1;
            if (a0) begin got++; d0 = d0 + 1; req0_data = d0; end
            if (a1) begin got++; d1 = d1 + 1; req1_data = d1; end
            budget++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("drive_budget", got, n);
    endtask

    task automatic drain();
        int budget = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        check_eq("drain_done", 32'(budget < 200), 1);
        @(posedge clock); #1;
    endtask

    task automatic single_op(input string tag);
        rsp0_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data  = '0;
        @(posedge clock); #1;
        req0_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            check_eq({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'(k == LATENCY));
            check_eq({tag, "_busy0"}, 32'(busy0), 32'(k <= LATENCY));
        end
        @(posedge clock); #1;
    endtask

    logic [DATA_W-1:0] held;
    int wait_b;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = d0; req1_data = d1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        n_rsp0 = 0; n_rsp1 = 0; first_rsp_cyc = -1; last_rsp_cyc = 0;

        // reset: outputs held quiet even with requests pending
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_req0_ready", 32'(req0_ready), 0);
        check_eq("rst_req1_ready", 32'(req1_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp0_valid | rsp1_valid), 0);
        check_eq("rst_busy", 32'(busy0 | busy1), 0);
        check_eq("rst_clk_en", 32'(pipe_clk_en), 1);
        check_eq("rst_aclr", 32'(pipe_aclr), 1);
        check_eq("rst_dataa", pipe_dataa, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // both stream: alternating grants, one result per cycle
        grant_log.delete();
        drive_until(1, 1, 32);
        drain();
        check_eq("stream_grants", grant_log.size(), 32);
        for (int i = 0; i < grant_log.size(); i++) check_eq("stream_alt", grant_log[i], i % 2);
        check_eq("stream_n0", n_rsp0, 16);
        check_eq("stream_n1", n_rsp1, 16);
        check_eq("stream_span", last_rsp_cyc - first_rsp_cyc, 31);

        // req1 alone moves rr_ptr back to req0
        grant_log.delete();
        drive_until(1, 1, 1);
        drive_until(0, 1, 5);
        drive_until(1, 1, 1);
        check_eq("rr_log_len", grant_log.size(), 7);
        if (grant_log.size() == 7) begin
            check_eq("rr_first", grant_log[0], 0);
            for (int i = 1; i <= 5; i++) check_eq("rr_req1_only", grant_log[i], 1);
            check_eq("rr_contention", grant_log[6], 0);
        end
        drain();

        single_op("single");

        // backpressure on req0
        drive_until(1, 0, 3);
        rsp0_ready = 1'b0;
        wait_b = 0;
        @(negedge clock);
        while (!rsp0_valid && wait_b < 40) begin @(negedge clock); wait_b++; end
        check_eq("bp_arrive", 32'(rsp0_valid), 1);
        held = rsp0_data;
        check_eq("bp_clk_en0", 32'(pipe_clk_en), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(negedge clock);
            check_eq("bp_clk_en", 32'(pipe_clk_en), 0);
            check_eq("bp_req_ready", 32'(req0_ready | req1_ready), 0);
            check_eq("bp_rsp_valid", 32'(rsp0_valid), 1);
            check_eq("bp_data_stable", rsp0_data, held);
        end
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("bp_release", 32'(rsp0_valid), 32'(i < 3));
        end
        drain();

        // tail owned by req1 stalls everything, req0 result behind it waits
        rsp1_ready = 1'b0;
        drive_until(0, 1, 1);
        drive_until(1, 0, 1);
        wait_b = 0;
        @(negedge clock);
        while (!rsp1_valid && wait_b < 40) begin @(negedge clock); wait_b++; end
        check_eq("mx_arrive", 32'(rsp1_valid), 1);
        held = rsp1_data;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            check_eq("mx_rsp0_valid", 32'(rsp0_valid), 0);
            check_eq("mx_clk_en", 32'(pipe_clk_en), 0);
            check_eq("mx_data_stable", rsp1_data, held);
        end
        @(posedge clock); #1;
        rsp1_ready = 1'b1;
        @(negedge clock);
        check_eq("mx_rel_rsp1", 32'(rsp1_valid), 1);
        @(negedge clock);
        check_eq("mx_rel_rsp0", 32'(rsp0_valid), 1);
        drain();

        // reset with 8 ops in flight
        drive_until(1, 1, 8);
        reset = 1'b1;
        q0.delete(); q1.delete();
        @(negedge clock);
        check_eq("mid_rst_busy", 32'(busy0 | busy1), 0);
        check_eq("mid_rst_clk_en", 32'(pipe_clk_en), 1);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq("post_rst_rsp", 32'(rsp0_valid | rsp1_valid), 0);
            check_eq("post_rst_busy", 32'(busy0 | busy1), 0);
        end
        @(posedge clock); #1;
        single_op("after_rst");
        drain();

        check_eq("end_q0_empty", q0.size(), 0);
        check_eq("end_q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
